axil_sram_ctrl: RTL and testbench

AXI4-Lite slave that converts single-beat bus reads and writes into command cycles on the single-port SRAM macro interface (chip select, write enable, word address, data, byte write mask). It sits directly upstream of the SRAM macro and drives its port 0. It serves one transaction at a time, arbitrates fairly between the read and write channels, and registers every SRAM-side output.

---
 rtl/axil_sram_ctrl_if.sv | 47 ++++
 rtl/axil_sram_ctrl.sv | 159 +++++++++++++++
 tb/tb_axil_sram_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_sram_ctrl_if.sv
// AXI4-Lite slave bus bundle for axil_sram_ctrl.
// master drives requests, slave drives readies and responses.
interface axil_sram_ctrl_if #(
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0] s_awaddr;
  logic                      s_awvalid;
  logic                      s_awready;
  logic [31:0]               s_wdata;
  logic [3:0]                s_wstrb;
  logic                      s_wvalid;
  logic                      s_wready;
  logic [1:0]                s_bresp;
  logic                      s_bvalid;
  logic                      s_bready;
  logic [AXI_ADDR_WIDTH-1:0] s_araddr;
  logic                      s_arvalid;
  logic                      s_arready;
  logic [31:0]               s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rvalid;
  logic                      s_rready;

  modport master (
    output s_awaddr, s_awvalid,
    output s_wdata, s_wstrb, s_wvalid,
    output s_bready,
    output s_araddr, s_arvalid,
    output s_rready,
    input  s_awready, s_wready,
    input  s_bresp, s_bvalid,
    input  s_arready,
    input  s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid,
    input  s_wdata, s_wstrb, s_wvalid,
    input  s_bready,
    input  s_araddr, s_arvalid,
    input  s_rready,
    output s_awready, s_wready,
    output s_bresp, s_bvalid,
    output s_arready,
    output s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axil_sram_ctrl.sv
// AXI4-Lite to single-port SRAM bridge, one transaction at a time.
// Optional SRAM_CTRL_ADDR_CHECK_EN: SLVERR outside the BASE_ADDR window.
module axil_sram_ctrl #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int SRAM_ADDR_WIDTH = 15,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  axil_sram_ctrl_if.slave            bus,
  output logic                       csb0,
  output logic                       web0,
  output logic [SRAM_ADDR_WIDTH-1:0] addr0,
  output logic [31:0]                din0,
  output logic [3:0]                 wmask0,
  input  logic [31:0]                dout0
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int SW = SRAM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, WR, BRESP, RD, RWAIT, RRESP
  } state_e;

  state_e          state_q;
  logic            rd_last_q;
  logic            csb_q;
  logic            web_q;
  logic [SW-1:0]   addr_q;
  logic [31:0]     din_q;
  logic [3:0]      mask_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic            rvalid_q;
  logic [1:0]      rresp_q;
  logic [31:0]     rdata_q;

  logic wr_pend;
  logic rd_pend;
  logic idle;
  logic wr_gnt;
  logic rd_gnt;
  logic aw_oor;
  logic ar_oor;
  logic unused_bits;

  assign wr_pend = bus.s_awvalid & bus.s_wvalid;
  assign rd_pend = bus.s_arvalid;
  assign idle    = rst_n & (state_q == IDLE);

  // rd_last_q=0 after reset, so a read wins the first tie
  assign rd_gnt = idle & rd_pend & (~wr_pend | ~rd_last_q);
  assign wr_gnt = idle & wr_pend & ~rd_gnt;

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  assign aw_oor = bus.s_awaddr[AW-1:SW+2] != BASE_ADDR[AW-1:SW+2];
  assign ar_oor = bus.s_araddr[AW-1:SW+2] != BASE_ADDR[AW-1:SW+2];
  assign unused_bits = ^{bus.s_awaddr[1:0], bus.s_araddr[1:0]};
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
  assign unused_bits = ^{bus.s_awaddr[1:0], bus.s_araddr[1:0],
                         bus.s_awaddr[AW-1:SW+2],
                         bus.s_araddr[AW-1:SW+2], BASE_ADDR};
`endif

  assign bus.s_awready = wr_gnt;
  assign bus.s_wready  = wr_gnt;
  assign bus.s_arready = rd_gnt;
  assign bus.s_bvalid  = bvalid_q;
  assign bus.s_bresp   = bresp_q;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rresp   = rresp_q;
  assign bus.s_rdata   = rdata_q;

  assign csb0   = csb_q;
  assign web0   = web_q;
  assign addr0  = addr_q;
  assign din0   = din_q;
  assign wmask0 = mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_last_q <= 1'b0;
      csb_q     <= 1'b1;
      web_q     <= 1'b1;
      addr_q    <= '0;
      din_q     <= '0;
      mask_q    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      csb_q <= 1'b1;
      web_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (wr_gnt) begin
            rd_last_q <= 1'b0;
            if (aw_oor) begin
              bresp_q  <= 2'b10;
              bvalid_q <= 1'b1;
              state_q  <= BRESP;
            end else begin
              addr_q  <= bus.s_awaddr[SW+1:2];
              din_q   <= bus.s_wdata;
              mask_q  <= bus.s_wstrb;
              csb_q   <= 1'b0;
              web_q   <= 1'b0;
              state_q <= WR;
            end
          end else if (rd_gnt) begin
            rd_last_q <= 1'b1;
            if (ar_oor) begin
              rresp_q  <= 2'b10;
              rdata_q  <= '0;
              rvalid_q <= 1'b1;
              state_q  <= RRESP;
            end else begin
              addr_q  <= bus.s_araddr[SW+1:2];
              csb_q   <= 1'b0;
              state_q <= RD;
            end
          end
        end
        WR: begin
          bresp_q  <= 2'b00;
          bvalid_q <= 1'b1;
          state_q  <= BRESP;
        end
        BRESP: begin
          if (bus.s_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RD: state_q <= RWAIT;
        RWAIT: begin
          rdata_q  <= dout0;
          rresp_q  <= 2'b00;
          rvalid_q <= 1'b1;
          state_q  <= RRESP;
        end
        RRESP: begin
          if (bus.s_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_sram_ctrl.sv
// Randomized bench for axil_sram_ctrl against a word-array model.
// SRAM macro modelled behaviourally with one-cycle read latency.
module tb_axil_sram_ctrl;

  localparam int AW = 32;
  localparam int SW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_sram_ctrl_if #(.AXI_ADDR_WIDTH(AW)) bus();

  logic          csb0;
  logic          web0;
  logic [SW-1:0] addr0;
  logic [31:0]   din0;
  logic [3:0]    wmask0;
  logic [31:0]   dout0 = '0;

  axil_sram_ctrl #(
    .AXI_ADDR_WIDTH (AW),
    .SRAM_ADDR_WIDTH(SW),
    .BASE_ADDR      (32'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .csb0  (csb0),
    .web0  (web0),
    .addr0 (addr0),
    .din0  (din0),
    .wmask0(wmask0),
    .dout0 (dout0)
  );

  // SRAM macro
  logic [31:0] sram [int];
  always @(posedge clk) begin
    logic [31:0] w;
    if (!csb0) begin
      w = sram.exists(int'(addr0)) ? sram[int'(addr0)] : 32'h0;
      if (!web0) begin
        for (int i = 0; i < 4; i++)
          if (wmask0[i]) w[8*i +: 8] = din0[8*i +: 8];
        sram[int'(addr0)] = w;
      end else begin
        dout0 <= w;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // reference model
  logic [31:0] ref_mem [int];
  bit last_rd = 1'b0;

  function automatic int widx(input logic [31:0] a);
    return int'(a[SW+1:2]);
  endfunction

  function automatic bit oor(input logic [31:0] a);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    return a[AW-1:SW+2] != '0;
`else
    return (a != a);
`endif
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    logic [31:0] w;
    w = ref_rd(a);
    for (int i = 0; i < 4; i++)
      if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[widx(a)] = w;
  endtask

  // csb0 must never be low in two consecutive cycles
  logic prev_csb = 1'b1;
  always @(negedge clk) begin
    if (rst_n && !csb0) chk("csb_gap", 32'(prev_csb), 32'd1);
    prev_csb = csb0;
  end

  task automatic wait_grant(output bit g_rd, output bit ok);
    ok = 1'b0;
    g_rd = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (bus.s_awready || bus.s_arready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok)
      chk("grant_timeout", 32'(bus.s_awready | bus.s_arready), 32'd1);
    else begin
      g_rd = bus.s_arready;
      chk("aw_w_ready", 32'(bus.s_awready), 32'(bus.s_wready));
    end
  endtask

  task automatic resp_wait(input bit is_rd, input logic [1:0] er,
                           input logic [31:0] ed);
    int n;
    logic sa, sw, sr;
    n = $urandom_range(0, 5);
    for (int k = 0; k <= n; k++) begin
      if (is_rd) begin
        chk("rvalid_hold", 32'(bus.s_rvalid), 32'd1);
        chk("rresp_hold", 32'(bus.s_rresp), 32'(er));
        chk("rdata_hold", bus.s_rdata, ed);
      end else begin
        chk("bvalid_hold", 32'(bus.s_bvalid), 32'd1);
        chk("bresp_hold", 32'(bus.s_bresp), 32'(er));
      end
      if (k == n) break;
      sa = bus.s_awvalid; sw = bus.s_wvalid; sr = bus.s_arvalid;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
      #1;
      chk("busy_ready", 32'({bus.s_awready, bus.s_arready}), 32'd0);
      bus.s_awvalid = sa; bus.s_wvalid = sw; bus.s_arvalid = sr;
      @(negedge clk);
    end
    if (is_rd) bus.s_rready = 1'b1;
    else       bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_rready = 1'b0;
    bus.s_bready = 1'b0;
    if (is_rd) chk("rvalid_drop", 32'(bus.s_rvalid), 32'd0);
    else       chk("bvalid_drop", 32'(bus.s_bvalid), 32'd0);
  endtask

  task automatic wr_tail(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    last_rd = 1'b0;
    if (oor(a)) begin
      chk("wr_oor_csb", 32'(csb0), 32'd1);
      resp_wait(1'b0, 2'b10, 32'h0);
    end else begin
      chk("wr_csb", 32'(csb0), 32'd0);
      chk("wr_web", 32'(web0), 32'd0);
      chk("wr_addr", 32'(addr0), 32'(widx(a)));
      chk("wr_din", din0, d);
      chk("wr_mask", 32'(wmask0), 32'(s));
      chk("wr_bvalid_early", 32'(bus.s_bvalid), 32'd0);
      ref_wr(a, d, s);
      @(negedge clk);
      resp_wait(1'b0, 2'b00, 32'h0);
    end
  endtask

  task automatic rd_tail(input logic [31:0] a, output logic [31:0] rd);
    logic [31:0] e;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    last_rd = 1'b1;
    if (oor(a)) begin
      rd = bus.s_rdata;
      resp_wait(1'b1, 2'b10, 32'h0);
    end else begin
      e = ref_rd(a);
      chk("rd_csb", 32'(csb0), 32'd0);
      chk("rd_web", 32'(web0), 32'd1);
      chk("rd_addr", 32'(addr0), 32'(widx(a)));
      @(negedge clk);
      chk("rwait_csb", 32'(csb0), 32'd1);
      chk("rwait_rvalid", 32'(bus.s_rvalid), 32'd0);
      @(negedge clk);
      rd = bus.s_rdata;
      resp_wait(1'b1, 2'b00, e);
    end
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    bit g, ok;
    bus.s_awaddr = a; bus.s_wdata = d; bus.s_wstrb = s;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    wait_grant(g, ok);
    if (ok) begin
      chk("wr_grant", 32'(g), 32'd0);
      wr_tail(a, d, s);
    end
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
  endtask

  task automatic do_rd(input logic [31:0] a, output logic [31:0] rd);
    bit g, ok;
    rd = 'x;
    bus.s_araddr = a;
    bus.s_arvalid = 1'b1;
    wait_grant(g, ok);
    if (ok) begin
      chk("rd_grant", 32'(g), 32'd1);
      rd_tail(a, rd);
    end
    bus.s_arvalid = 1'b0;
  endtask

  // both channels requested; redrive keeps the served one pending
  task automatic do_mix(input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] ra,
                        input int n, input bit redrive);
    bit pw, pr, g, ok, e;
    logic [31:0] rd;
    pw = 1'b1; pr = 1'b1;
    bus.s_awaddr = wa; bus.s_wdata = wd; bus.s_wstrb = ws;
    bus.s_araddr = ra;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
    for (int k = 0; k < n; k++) begin
      e = pr && (!pw || !last_rd);
      wait_grant(g, ok);
      if (!ok) break;
      chk("grant_order", 32'(g), 32'(e));
      if (g) begin
        pr = 1'b0;
        rd_tail(ra, rd);
        if (redrive) begin bus.s_arvalid = 1'b1; pr = 1'b1; end
      end else begin
        pw = 1'b0;
        wr_tail(wa, wd, ws);
        if (redrive) begin
          bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; pw = 1'b1;
        end
      end
    end
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, a, ra, d;
    bit g, ok;
    int op;
    bus.s_awaddr = '0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_araddr = '0; bus.s_bready = 1'b0; bus.s_rready = 1'b0;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_csb", 32'(csb0), 32'd1);
    chk("rst_web", 32'(web0), 32'd1);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_din", din0, 32'd0);
    chk("rst_mask", 32'(wmask0), 32'd0);
    chk("rst_bvalid", 32'(bus.s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    chk("rst_bresp", 32'(bus.s_bresp), 32'd0);
    chk("rst_rresp", 32'(bus.s_rresp), 32'd0);
    chk("rst_rdata", bus.s_rdata, 32'd0);
    chk("rst_ready",
        32'({bus.s_awready, bus.s_wready, bus.s_arready}), 32'd0);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // three back-to-back ties from reset: read, write, read
    do_mix(32'h40, 32'hCAFE_0001, 4'hF, 32'h44, 3, 1'b1);
    @(negedge clk);

    do_wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    do_rd(32'h10, rd);
    chk("deadbeef", rd, 32'hDEAD_BEEF);

    do_wr(32'h20, 32'h1122_3344, 4'hF);
    do_wr(32'h20, 32'hAABB_CCDD, 4'b0101);
    do_rd(32'h22, rd);
    chk("partial", rd, 32'h11BB_33DD);

    do_wr(32'h30, 32'h5555_AAAA, 4'h0);
    do_rd(32'h30, rd);
    chk("zero_strb", rd, 32'h0);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    do_wr(32'h0002_0000, 32'h1234_5678, 4'hF);
    do_rd(32'h0002_0000, rd);
    chk("oor_rdata", rd, 32'h0);
    do_rd(32'h0, rd);
    chk("oor_no_write", rd, 32'h0);
`else
    do_wr(32'h0002_0000, 32'h1234_5678, 4'hF);
    do_rd(32'h0, rd);
    chk("alias", rd, 32'h1234_5678);
`endif

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      a  = ($urandom_range(0, 1) ? ($urandom & 32'h0006_0000) : 32'h0)
         | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0 ? ($urandom & 32'h0006_0000) : 32'h0)
         | (32'($urandom_range(0, 15)) << 2);
      d  = $urandom;
      if (op == 0) do_wr(a, d, 4'($urandom_range(0, 15)));
      else if (op == 1) do_rd(a, rd);
      else do_mix(a, d, 4'($urandom_range(0, 15)), ra, 2, 1'b0);
    end

    // reset landing in RWAIT drops the read
    bus.s_araddr = 32'h10;
    bus.s_arvalid = 1'b1;
    wait_grant(g, ok);
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.s_arvalid = 1'b1;
    #1;
    chk("rwait_rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    chk("rwait_rst_csb", 32'(csb0), 32'd1);
    chk("rwait_rst_ready", 32'(bus.s_arready), 32'd0);
    @(negedge clk);
    chk("rwait_rst_hold", 32'(bus.s_rvalid), 32'd0);
    bus.s_arvalid = 1'b0;
    rst_n = 1'b1;
    last_rd = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    do_rd(32'h10, rd);
    chk("post_rst_read", rd, ref_rd(32'h10));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
